// File: rtl/smac_result_packer.sv
// smac_result_packer: tracks in-flight SMAC results, packs them by precision into 64-bit words, buffers them in a FIFO
module smac_result_packer #(
   parameter int FIFO_DEPTH  = 8,
   parameter int MAX_LATENCY = 15
) (
   input  logic        clk,
   input  logic        sclr,
   input  logic        ce,
   input  logic        issue,
   input  logic [3:0]  latency,
   input  logic [3:0]  select_precision,
   input  logic [63:0] res_mac_n,
   input  logic        flush,
   output logic [63:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [4:0]  count,
   output logic        overflow,
   output logic        prec_err,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [MAX_LATENCY-1:0] trk;
   logic [MAX_LATENCY-1:0] lat_mask;
   logic [3:0]             lat_e;
   logic                   sample;
   logic                   illegal;
   logic [1:0]             p_in;
   logic [1:0]             p_q;
   logic [1:0]             p;
   logic [2:0]             lane;
   logic                   last;
   logic [63:0]            acc;
   logic [63:0]            lane_val;
   logic [63:0]            next_word;
   logic [63:0]            push_word;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   wr_en;
   logic [63:0]            mem [FIFO_DEPTH];
   logic [AW-1:0]          wp;
   logic [AW-1:0]          rp;

   // Latency 0 behaves as 1; deeper requests clamp to the tracker length.
   assign lat_e    = latency == 4'd0 ? 4'd1 : (latency > 4'(MAX_LATENCY) ? 4'(MAX_LATENCY) : latency);
   assign lat_mask = ~({MAX_LATENCY{1'b1}} << lat_e);
   assign sample   = ce & trk[lat_e - 4'd1];

   // Precision code: 0=8b, 1=16b, 2=32b, 3=64b; non-one-hot falls back to 64b.
   assign illegal  = !$onehot(select_precision);
   assign p_in     = illegal ? 2'd3 : select_precision[0] ? 2'd0 : select_precision[1] ? 2'd1 : select_precision[2] ? 2'd2 : 2'd3;
   assign p        = lane == 3'd0 ? p_in : p_q;

   // Lane j of width W = 8<<p lands at bit j*W; the mask shift of 64 yields a full-width mask.
   assign lane_val  = (res_mac_n & ~(64'hFFFF_FFFF_FFFF_FFFF << (7'd8 << p))) << ({lane, 3'b000} << p);
   assign next_word = acc | lane_val;
   assign last      = lane == (3'd7 >> p);
   assign push      = (sample & last) | (flush & (sample | lane != 3'd0));
   assign push_word = sample ? next_word : acc;

   assign m_valid = count != 5'd0;
   assign m_data  = m_valid ? mem[rp] : 64'd0;
   assign pop     = m_valid & m_ready;
   assign full    = count == 5'(FIFO_DEPTH);
   assign wr_en   = push & (~full | pop);
   assign busy    = |(trk & lat_mask) | lane != 3'd0 | m_valid;

   // Tracker shift, precision latch and lane accumulation.
   always_ff @(posedge clk) begin
      if (sclr) begin
         trk      <= '0;
         acc      <= '0;
         lane     <= '0;
         p_q      <= 2'd3;
         prec_err <= 1'b0;
      end else begin
         if (ce) trk <= {trk[MAX_LATENCY-2:0], issue};
         if (lane == 3'd0) begin
            p_q      <= p_in;
            prec_err <= prec_err | illegal;
         end
         if (push) begin
            acc  <= '0;
            lane <= '0;
         end else if (sample) begin
            acc  <= next_word;
            lane <= lane + 3'd1;
         end
      end
   end

   // FIFO storage needs no reset; reads are masked by m_valid.
   always_ff @(posedge clk) begin
      if (!sclr && wr_en) mem[wp] <= push_word;
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (sclr) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + 5'(wr_en) - 5'(pop);
         if (push & ~wr_en) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_smac_result_packer.sv
// tb_smac_result_packer: scoreboard bench for smac_result_packer with a behavioural SMAC column
module tb_smac_result_packer;
   logic        clk = 1'b0;
   logic        sclr = 1'b1;
   logic        ce = 1'b1;
   logic        issue = 1'b0;
   logic [3:0]  latency = 4'd3;
   logic [3:0]  select_precision = 4'b1000;
   logic [63:0] res_mac_n;
   logic        flush = 1'b0;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [4:0]  count;
   logic        overflow;
   logic        prec_err;
   logic        busy;
   logic [63:0] opnd = 64'd0;
   logic [63:0] col [1:15];
   logic [63:0] sb [$];
   logic [63:0] exp_w;
   int          checks = 0;
   int          errors = 0;
   int          maxc;

   smac_result_packer #(.FIFO_DEPTH(8), .MAX_LATENCY(15)) dut (
      .clk(clk), .sclr(sclr), .ce(ce), .issue(issue), .latency(latency),
      .select_precision(select_precision), .res_mac_n(res_mac_n), .flush(flush),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
      .overflow(overflow), .prec_err(prec_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Column model: operands travel a ce-gated pipe and emerge at depth latency.
   initial for (int k = 1; k <= 15; k++) col[k] = 64'd0;
   always @(posedge clk) begin
      if (ce) begin
         col[1] <= issue ? opnd : 64'd0;
         for (int k = 2; k <= 15; k++) col[k] <= col[k-1];
      end
   end
   assign res_mac_n = col[latency];

   // Monitor: every accepted word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!sclr && m_valid && m_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got %h expected none", m_data);
         end else begin
            exp_w = sb.pop_front();
            if (m_data !== exp_w) begin
               errors++;
               $display("FAIL pop_data got %h expected %h", m_data, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic iss(input logic [63:0] v);
      issue = 1'b1;
      opnd  = v;
      tick();
      issue = 1'b0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_data"}, m_data, 64'd0);
      chk({tag, "_count"}, 64'(count), 64'd0);
      chk({tag, "_overflow"}, 64'(overflow), 64'd0);
      chk({tag, "_prec_err"}, 64'(prec_err), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      ticks(2);
      sclr = 1'b0;
      chk_reset("reset");

      // 64-bit, latency 3
      sb.push_back(64'h1122334455667788);
      sb.push_back(64'h0F0F0F0F0F0F0F0F);
      iss(64'h1122334455667788);
      iss(64'h0F0F0F0F0F0F0F0F);
      tick();
      chk("p64_early", 64'(m_valid), 64'd0);
      tick();
      chk("p64_valid", 64'(m_valid), 64'd1);
      chk("p64_head", m_data, 64'h1122334455667788);
      maxc = int'(count);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (int'(count) > maxc) maxc = int'(count);
      end
      chk("p64_maxcount", 64'(maxc), 64'd1);
      chk("p64_busy_idle", 64'(busy), 64'd0);

      // 8-bit packing, latency 2
      select_precision = 4'b0001;
      latency = 4'd2;
      sb.push_back(64'h0807060504030201);
      for (int i = 1; i <= 8; i++) iss(64'hFF00_0000_0000_0000 | 64'(i));
      tick();
      chk("p8_not_before_8th", 64'(m_valid), 64'd0);
      tick();
      chk("p8_valid", 64'(m_valid), 64'd1);
      ticks(3);

      // 16-bit partial flush
      select_precision = 4'b0010;
      sb.push_back(64'h00000000BBBBAAAA);
      iss(64'hDEAD_0000_0000_AAAA);
      iss(64'hBEEF_0000_0000_BBBB);
      ticks(2);
      chk("p16_no_word_yet", 64'(m_valid), 64'd0);
      chk("p16_busy_partial", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("p16_flush_valid", 64'(m_valid), 64'd1);
      ticks(2);
      chk("p16_drained", 64'(count), 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("p16_empty_flush_count", 64'(count), 64'd0);
      chk("p16_empty_flush_valid", 64'(m_valid), 64'd0);

      // 32-bit with a 3-cycle ce stall
      select_precision = 4'b0100;
      latency = 4'd3;
      sb.push_back(64'h2222222211111111);
      iss(64'hAAAA_BBBB_1111_1111);
      iss(64'hCCCC_DDDD_2222_2222);
      ce = 1'b0;
      ticks(3);
      ce = 1'b1;
      ticks(2);
      chk("stall_not_early", 64'(m_valid), 64'd0);
      tick();
      chk("stall_valid", 64'(m_valid), 64'd1);
      ticks(3);

      // Backpressure and overflow, 64-bit, latency 1
      select_precision = 4'b1000;
      latency = 4'd1;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) sb.push_back(64'hA5A5_0000_0000_0000 | 64'(i));
      for (int i = 0; i < 9; i++) iss(64'hA5A5_0000_0000_0000 | 64'(i));
      ticks(2);
      chk("bp_count_full", 64'(count), 64'd8);
      chk("bp_overflow", 64'(overflow), 64'd1);
      chk("bp_head", m_data, 64'hA5A5_0000_0000_0000);
      m_ready = 1'b1;
      ticks(10);
      chk("bp_drained", 64'(count), 64'd0);
      chk("bp_overflow_sticky", 64'(overflow), 64'd1);

      // Full FIFO with concurrent push and pop, then reset mid-flight
      sclr = 1'b1;
      sb.delete();
      tick();
      sclr = 1'b0;
      chk("rst2_overflow", 64'(overflow), 64'd0);
      latency = 4'd3;
      m_ready = 1'b0;
      for (int i = 0; i < 9; i++) sb.push_back(64'hF000_0000_0000_0000 | 64'(i));
      for (int i = 0; i < 8; i++) iss(64'hF000_0000_0000_0000 | 64'(i));
      ticks(3);
      chk("full_count", 64'(count), 64'd8);
      iss(64'hF000_0000_0000_0008);
      ticks(2);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("full_pushpop_count", 64'(count), 64'd8);
      chk("full_pushpop_overflow", 64'(overflow), 64'd0);
      chk("full_pushpop_head", m_data, 64'hF000_0000_0000_0001);
      iss(64'h0123_4567_89AB_CDEF);
      tick();
      sclr = 1'b1;
      sb.delete();
      tick();
      sclr = 1'b0;
      chk_reset("sclr_mid");
      ticks(4);
      chk("post_sclr_no_sample", 64'(m_valid), 64'd0);
      chk("post_sclr_busy", 64'(busy), 64'd0);

      // Illegal precision falls back to 64-bit and sets the sticky error
      select_precision = 4'b0011;
      latency = 4'd1;
      m_ready = 1'b1;
      sb.push_back(64'h5A5A_1234_5678_9ABC);
      iss(64'h5A5A_1234_5678_9ABC);
      select_precision = 4'b1000;
      ticks(3);
      chk("illegal_prec_err", 64'(prec_err), 64'd1);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      chk("final_count", 64'(count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
